// File: rtl/conv2d_frame_sequencer.sv
// Frame controller for the 4x4 conv2d layer: holds weights/bias loaded over a config
// handshake, streams one frame from a 1-cycle-latency pixel memory and frames the results.
module conv2d_frame_sequencer #(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [DATA_WIDTH-1:0]      cfg_data,
    output logic                       mem_rd_en,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    input  logic [DATA_WIDTH-1:0]      mem_rd_data,
    output logic                       conv_rst_n,
    output logic                       conv_valid_in,
    output logic [DATA_WIDTH-1:0]      conv_data_in,
    output logic [16*DATA_WIDTH-1:0]   w_flat,
    output logic [DATA_WIDTH-1:0]      bias,
    input  logic                       conv_valid_out,
    input  logic [DATA_WIDTH-1:0]      conv_data_out,
    output logic                       out_valid,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic                       weights_loaded
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_WIDTH*IMG_HEIGHT-1);
    localparam logic [15:0]           EXP       = 16'((IMG_HEIGHT-3)*(IMG_WIDTH-3));

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t                  r_state, w_next;
    logic [DATA_WIDTH-1:0]   r_slot [0:16];
    logic [4:0]              r_cfg_idx;
    logic                    r_weights_loaded;
    logic [ADDR_WIDTH-1:0]   r_pix_cnt;
    logic [15:0]             r_res_cnt;
    logic [2:0]              r_drain_cnt;
    logic                    r_conv_valid_in;
    logic                    r_out_valid;
    logic                    r_out_last;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic                    r_err;

    logic                    w_cfg_fire;
    logic                    w_start_ok;
    logic                    w_res_window;
    logic [15:0]             w_res_base;
    logic                    w_res_accept;
    logic                    w_res_complete;
    logic                    w_timeout;

    // Config handshake: a word transfers on any rising edge where cfg_valid && cfg_ready;
    // ready is only offered in IDLE without a competing start, so a frame request always wins.
    assign cfg_ready      = (r_state == S_IDLE) && !start;
    assign w_cfg_fire     = cfg_valid && cfg_ready;
    assign w_start_ok     = (r_state == S_IDLE) && start && r_weights_loaded;
    assign w_res_window   = (r_state == S_CLEAR) || (r_state == S_STREAM) || (r_state == S_DRAIN);
    // CLEAR zeroes the count, so a result landing there is counted from zero.
    assign w_res_base     = (r_state == S_CLEAR) ? 16'd0 : r_res_cnt;
    assign w_res_accept   = w_res_window && conv_valid_out && (w_res_base < EXP);
    assign w_res_complete = (r_res_cnt == EXP);
    assign w_timeout      = (r_drain_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        mem_rd_en  = 1'b0;
        conv_rst_n = 1'b1;
        busy       = (r_state != S_IDLE);
        done       = 1'b0;
        case (r_state)
            S_IDLE:   if (w_start_ok) w_next = S_CLEAR;
            S_CLEAR: begin
                conv_rst_n = 1'b0;
                w_next     = S_STREAM;
            end
            S_STREAM: begin
                mem_rd_en = 1'b1;
                if (r_pix_cnt == LAST_ADDR) w_next = S_DRAIN;
            end
            S_DRAIN:  if (w_res_complete || w_timeout) w_next = S_DONE;
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default:  w_next = S_IDLE;
        endcase
        if (abort && (r_state != S_IDLE)) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 17; k++) r_slot[k] <= '0;
            r_cfg_idx        <= '0;
            r_weights_loaded <= 1'b0;
        end else if (w_cfg_fire) begin
            r_slot[r_cfg_idx] <= cfg_data;
            if (r_cfg_idx == 5'd16) begin
                r_cfg_idx        <= '0;
                r_weights_loaded <= 1'b1;
            end else begin
                r_cfg_idx <= r_cfg_idx + 5'd1;
                if (r_cfg_idx == 5'd0) r_weights_loaded <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_cnt       <= '0;
            r_res_cnt       <= '0;
            r_drain_cnt     <= '0;
            r_conv_valid_in <= 1'b0;
            r_out_valid     <= 1'b0;
            r_out_last      <= 1'b0;
            r_out_data      <= '0;
            r_err           <= 1'b0;
        end else begin
            if (r_state == S_CLEAR)       r_pix_cnt <= '0;
            else if (r_state == S_STREAM) r_pix_cnt <= r_pix_cnt + 1'b1;

            if (w_res_accept)             r_res_cnt <= w_res_base + 16'd1;
            else if (r_state == S_CLEAR)  r_res_cnt <= '0;

            r_drain_cnt     <= (r_state == S_DRAIN) ? r_drain_cnt + 3'd1 : 3'd0;
            r_conv_valid_in <= mem_rd_en && !abort;
            r_out_valid     <= w_res_accept;
            r_out_last      <= w_res_accept && (w_res_base == EXP - 16'd1);
            if (w_res_accept) r_out_data <= conv_data_out;

            if (w_start_ok)
                r_err <= 1'b0;
            else if ((r_state == S_DRAIN) && w_timeout && !w_res_complete && !abort)
                r_err <= 1'b1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < 16; g++) begin : g_wflat
            assign w_flat[g*DATA_WIDTH +: DATA_WIDTH] = r_slot[g];
        end
    endgenerate

    assign bias           = r_slot[16];
    assign mem_addr       = r_pix_cnt;
    assign conv_valid_in  = r_conv_valid_in;
    assign conv_data_in   = mem_rd_data;
    assign out_valid      = r_out_valid;
    assign out_data       = r_out_data;
    assign out_last       = r_out_last;
    assign err            = r_err;
    assign weights_loaded = r_weights_loaded;

endmodule

// File: tb/tb_conv2d_frame_sequencer.sv
// Directed bench for conv2d_frame_sequencer: pixel memory, a behavioural 4x4 layer stub
// with 2-cycle latency, a negedge monitor and a linear sequence of checked steps.
module tb_conv2d_frame_sequencer;

    localparam int W   = 16;
    localparam int H   = 16;
    localparam int DW  = 16;
    localparam int AW  = 8;
    localparam int N   = W*H;
    localparam int EXP = (H-3)*(W-3);

    logic              clk = 1'b0;
    logic              rst, start, abort, cfg_valid, cfg_ready;
    logic [DW-1:0]     cfg_data;
    logic              mem_rd_en;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_rd_data;
    logic              conv_rst_n, conv_valid_in;
    logic [DW-1:0]     conv_data_in;
    logic [16*DW-1:0]  w_flat;
    logic [DW-1:0]     bias;
    logic              conv_valid_out;
    logic [DW-1:0]     conv_data_out;
    logic              out_valid, out_last, busy, done, err, weights_loaded;
    logic [DW-1:0]     out_data;

    always #5 clk = ~clk;

    conv2d_frame_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .conv_rst_n(conv_rst_n), .conv_valid_in(conv_valid_in), .conv_data_in(conv_data_in),
        .w_flat(w_flat), .bias(bias),
        .conv_valid_out(conv_valid_out), .conv_data_out(conv_data_out),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .err(err), .weights_loaded(weights_loaded)
    );

    // ---------------- pixel memory, 1-cycle read latency ----------------
    logic [DW-1:0] img [0:N-1];
    logic [DW-1:0] mem_q;
    always @(posedge clk) if (mem_rd_en) mem_q <= img[mem_addr];
    assign mem_rd_data = mem_q;

    // ---------------- layer stub ----------------
    logic [DW-1:0] s_buf [0:N-1];
    int            s_cnt;
    logic          s_v1, s_vout, s_drop1;
    logic [DW-1:0] s_d1, s_dout;
    bit            suppress_last;

    function automatic logic [DW-1:0] win_sum(input int idx, input logic [DW-1:0] cur);
        int r, c, pos;
        logic [DW-1:0] px, wv;
        logic signed [31:0] acc, p, wk;
        r = idx / W;
        c = idx % W;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                pos = (r - i) * W + (c - j);
                px  = (pos == idx) ? cur : s_buf[pos];
                wv  = w_flat[(i*4+j)*DW +: DW];
                p   = {{16{px[DW-1]}}, px};
                wk  = {{16{wv[DW-1]}}, wv};
                acc = acc + ((p * wk) >>> 8);
            end
        end
        acc = acc + {{16{bias[DW-1]}}, bias};
        return acc[DW-1:0];
    endfunction

    always @(posedge clk) begin
        if (rst || !conv_rst_n) begin
            s_cnt  <= 0;
            s_v1   <= 1'b0;
            s_vout <= 1'b0;
        end else begin
            s_v1 <= 1'b0;
            if (conv_valid_in && s_cnt < N) begin
                s_buf[s_cnt] <= conv_data_in;
                s_cnt        <= s_cnt + 1;
                if ((s_cnt / W) >= 3 && (s_cnt % W) >= 3) begin
                    s_v1    <= 1'b1;
                    s_d1    <= win_sum(s_cnt, conv_data_in);
                    s_drop1 <= suppress_last && (s_cnt == N-1);
                end
            end
            s_vout <= s_v1 && !s_drop1;
            s_dout <= s_d1;
        end
    end
    assign conv_valid_out = s_vout;
    assign conv_data_out  = s_dout;

    // ---------------- cycle counter and monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] got_q[$];
    logic [DW-1:0] exp_q[$];
    int rstn_cnt, rstn_cyc, rd_cnt, first_rd, last_vin, last_ov;
    int last_cnt, last_idx, done_cnt, done_cyc, busy_cnt;

    always @(negedge clk) begin
        if (!conv_rst_n) begin rstn_cnt++; rstn_cyc = cyc; end
        if (mem_rd_en) begin
            if (rd_cnt == 0) first_rd = cyc;
            rd_cnt++;
        end
        if (conv_valid_in) last_vin = cyc;
        if (out_valid) begin
            got_q.push_back(out_data);
            last_ov = cyc;
            if (out_last) begin last_cnt++; last_idx = got_q.size() - 1; end
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (busy) busy_cnt++;
    end

    task automatic clear_stats();
        got_q.delete();
        rstn_cnt = 0; rstn_cyc = -1; rd_cnt = 0; first_rd = -1; last_vin = -1; last_ov = -1;
        last_cnt = 0; last_idx = -1; done_cnt = 0; done_cyc = -1; busy_cnt = 0;
    endtask

    // ---------------- checking ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_results(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_res%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_cfg(input logic [DW-1:0] wv, input logic [DW-1:0] bv);
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            if (k == 1)  check("wl_cleared_after_word0", weights_loaded, 0);
            if (k == 16) check("wl_low_before_word16", weights_loaded, 0);
            cfg_valid = 1'b1;
            cfg_data  = (k < 16) ? wv : bv;
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        check("wl_set_after_word16", weights_loaded, 1);
    endtask

    task automatic run_frame(input bit with_cfg, output int t0, output logic t1_err);
        bit seen;
        seen = 0;
        @(negedge clk);
        clear_stats();
        start = 1'b1;
        t0 = cyc;
        if (with_cfg) begin
            cfg_valid = 1'b1;
            cfg_data  = 16'hBEEF;
            #1 check("cfg_ready_blocked_by_start", cfg_ready, 0);
        end
        @(negedge clk);
        start     = 1'b0;
        cfg_valid = 1'b0;
        t1_err    = err;
        check("conv_rst_n_low_t1", conv_rst_n, 0);
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("done_seen", seen, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
    endtask

    // ---------------- directed sequence ----------------
    int   t0;
    logic t1_err;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        suppress_last = 0;
        for (int i = 0; i < N; i++) img[i] = '0;
        clear_stats();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_wl", weights_loaded, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_vin", conv_valid_in, 0);
        check("rst_conv_rst_n", conv_rst_n, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_w_flat_lo", w_flat[63:0], 0);
        check("rst_bias", bias, 0);
        rst = 1'b0;

        // start with no weights loaded is ignored
        @(negedge clk);
        clear_stats();
        start = 1'b1;
        #1 check("nowt_cfg_ready", cfg_ready, 0);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("nowt_busy_cnt", busy_cnt, 0);
        check("nowt_rd_cnt", rd_cnt, 0);
        check("nowt_rstn_cnt", rstn_cnt, 0);

        // load unity weights, zero bias
        load_cfg(16'h0100, 16'h0000);
        check("w0", w_flat[0 +: DW], 16'h0100);
        check("w15", w_flat[15*DW +: DW], 16'h0100);
        check("bias0", bias, 16'h0000);

        // frame of all 1.0 with a simultaneous cfg word that must not be taken
        for (int i = 0; i < N; i++) img[i] = 16'h0100;
        exp_q.delete();
        for (int i = 0; i < EXP; i++) exp_q.push_back(16'h1000);
        run_frame(1, t0, t1_err);
        compare_results("ones");
        check("ones_last_cnt", last_cnt, 1);
        check("ones_last_idx", last_idx, EXP-1);
        check("ones_rstn_cyc", rstn_cyc, t0+1);
        check("ones_first_rd", first_rd, t0+2);
        check("ones_rd_cnt", rd_cnt, N);
        check("ones_last_vin", last_vin, t0+N+2);
        check("ones_last_ov", last_ov, t0+N+5);
        check("ones_done_cyc", done_cyc, t0+262);
        check("ones_done_cnt", done_cnt, 1);
        check("ones_err", err, 0);
        check("ones_busy_after", busy, 0);
        check("cfg_word_not_taken_w0", w_flat[0 +: DW], 16'h0100);
        check("cfg_word_not_taken_bias", bias, 16'h0000);

        // abort at the 100th STREAM cycle
        @(negedge clk);
        clear_stats();
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && cyc < t0+101; i++) @(negedge clk);
        check("abort_reached_cycle", cyc, t0+101);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_rd_en", mem_rd_en, 0);
        check("abort_vin", conv_valid_in, 0);
        check("abort_rd_cnt", rd_cnt, 100);
        repeat (20) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        check("abort_no_out_valid_idle", out_valid, 0);
        check("abort_wl_kept", weights_loaded, 1);

        // rerun after abort
        run_frame(0, t0, t1_err);
        compare_results("rerun");
        check("rerun_last_idx", last_idx, EXP-1);
        check("rerun_done_cyc", done_cyc, t0+N+6);

        // layer drops its final result: drain timeout
        suppress_last = 1;
        exp_q.delete();
        for (int i = 0; i < EXP-1; i++) exp_q.push_back(16'h1000);
        run_frame(0, t0, t1_err);
        suppress_last = 0;
        compare_results("tmo");
        check("tmo_no_last", last_cnt, 0);
        check("tmo_done_cyc", done_cyc, t0+N+10);
        check("tmo_done_cnt", done_cnt, 1);
        check("tmo_err", err, 1);
        repeat (3) @(negedge clk);
        check("tmo_err_sticky", err, 1);

        // reload with bias 0x0010; err survives config
        load_cfg(16'h0100, 16'h0010);
        check("bias_reload", bias, 16'h0010);
        check("err_after_cfg", err, 1);

        // back-to-back: ramp frame then zero frame
        for (int i = 0; i < N; i++) img[i] = DW'(i);
        exp_q.delete();
        for (int r = 3; r < H; r++)
            for (int c = 3; c < W; c++)
                exp_q.push_back(DW'(256*r + 16*c - 408 + 16));
        run_frame(0, t0, t1_err);
        check("ramp_err_cleared_by_start", t1_err, 0);
        compare_results("ramp");
        check("ramp_last_idx", last_idx, EXP-1);

        for (int i = 0; i < N; i++) img[i] = '0;
        exp_q.delete();
        for (int i = 0; i < EXP; i++) exp_q.push_back(16'h0010);
        run_frame(0, t0, t1_err);
        compare_results("zero");
        check("zero_rstn_pulse", rstn_cnt, 1);
        check("zero_last_cnt", last_cnt, 1);
        check("zero_done_cyc", done_cyc, t0+N+6);
        check("zero_err", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
